quadrature_input_filter: RTL and testbench
==========================================

Name: quadrature_input_filter

Overview:
Conditions the raw A/B encoder pins before they reach quadrature_encoder. Each channel gets a multi-flop synchronizer and a consecutive-sample glitch filter. The block outputs clean enc[1:0] that feeds quadrature_encoder.enc directly. It also flags illegal two-bit jumps and emits a single-cycle strobe on every legal edge.

Parameters:
SYNC_STAGES, 2, synchronizer depth per channel; legal range 2..4.
FILTER_CYCLES, 4, number of consecutive differing synchronized samples needed to accept a new level; legal range 1..15.
CNT_W, 4, width of each channel's filter counter; must hold FILTER_CYCLES-1.

Ports:
clk  input  1  system clock, 100 MHz nominal.
reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
enc_raw  input  2  asynchronous encoder pins; bit0 = A, bit1 = B.
err_clr  input  1  synchronous clear for err, active-high.
enc  output  2  filtered, synchronous A/B level to quadrature_encoder.
step  output  1  one-cycle pulse when exactly one enc bit changed on that edge.
err  output  1  sticky flag: both enc bits changed on the same edge.

Behaviour:
- Reset (reset=0) acts asynchronously and holds while low. It clears:
  - all synchronizer flops to 0,
  - both filter counters to 0,
  - enc = 2'b00, step = 0, err = 0.
- Reset release is synchronous in effect. The first update occurs on the first rising edge with reset=1.
- Synchronizer: per bit, a chain of SYNC_STAGES flops. The last stage is s[i].
- Filter, per bit i, evaluated on every rising edge:
  - If s[i] == enc[i]: cnt[i] <= 0.
  - Else if cnt[i] == FILTER_CYCLES-1: enc[i] <= s[i], cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
- Any sample where s[i] returns to enc[i] restarts the count. A pulse shorter than FILTER_CYCLES synchronized samples never reaches enc.
- Latency: let edge k be the first rising edge at which enc_raw[i] has its new stable value. enc[i] changes on edge k+SYNC_STAGES+FILTER_CYCLES-1, a total of SYNC_STAGES+FILTER_CYCLES cycles (6 at defaults).
- FILTER_CYCLES=1 degenerates to a pure synchronizer with latency SYNC_STAGES.
- step and err are registered and derived from the enc update computed on the same edge:
  - Exactly one bit of enc updates: step <= 1 for one cycle, otherwise 0.
  - Both bits update on the same edge: step <= 0, err <= 1 (illegal quadrature transition).
- err is sticky:
  - err_clr=1 clears it on the next edge.
  - A new illegal jump on the same edge as err_clr=1 leaves err=1 (set wins).
  - err_clr has no effect on enc, step or counters.
- Channels are independent. The two counters may be mid-count simultaneously with no interaction.
- Counter saturation is not needed: the counter never exceeds FILTER_CYCLES-1.
- Reset mid-filter: the count is discarded and enc returns to 00. A raw level of 1 held through reset then requires the full latency again after release. step stays 0 across reset entry and exit; the forced return to 00 is not an edge.
- Out-of-range parameters are a configuration error; behaviour for them is not specified.

Test Plan:
1. Reset: hold reset=0 with enc_raw=11 for 5 cycles, then release. Required: enc=00, step=0, err=0 throughout reset. enc=11 and err=1 exactly 6 edges after release, both bits updating on the same edge.
2. Latency/legal edge (defaults): from enc=00, set enc_raw=01 before edge k. Required: enc=01 at edge k+5, step=1 for one cycle at k+5, err=0. Then set enc_raw=11. Required: enc=11 five edges after it is sampled, with one step pulse.
3. Glitch reject: from enc=00, drive enc_raw[0]=1 for 3 cycles, then back to 0. Required: enc stays 00, no step. The same pulse held for 4 cycles does pass, with enc[0]=1 on edge k+5.
4. Restart on bounce: drive pattern 1,1,1,0,1,1,1,1 on enc_raw[1]. Required: the count restarts after the 0. enc[1] rises only after the final four synchronized 1s.
5. Illegal jump and clear: from enc=00, switch enc_raw to 11 in one step. Required: enc=11, err=1, step=0. Pulse err_clr for 1 cycle. Required: err=0 next edge. Then drive 11→00 with err_clr held high. Required: err=1 remains set.
6. Full CW sequence into quadrature_encoder: drive 00→01→11→10→00 with each level held 10 cycles. Required: exactly 4 step pulses, err=0, and the downstream count advances by 4.

Source files
------------

// File: rtl/quadrature_input_filter.sv
// Synchronizes and glitch-filters the A/B encoder pins; enc follows a raw level after SYNC_STAGES+FILTER_CYCLES cycles.
// No backpressure: one sample per clock, step/err are registered alongside each enc update.
module quadrature_input_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] enc_raw,
  input  logic       err_clr,
  output logic [1:0] enc,
  output logic       step,
  output logic       err
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

  logic [1:0]       sync_q [SYNC_STAGES];
  logic [1:0]       sync_d [SYNC_STAGES];
  logic [CNT_W-1:0] cnt_q  [2];
  logic [CNT_W-1:0] cnt_d  [2];
  logic [1:0]       enc_q, enc_d;
  logic             step_q, step_d;
  logic             err_q, err_d;
  logic [1:0]       s;
  logic [1:0]       upd;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = enc_raw;
    for (int j = 1; j < SYNC_STAGES; j++) begin
      sync_d[j] = sync_q[j-1];
    end
  end

  // A channel's count restarts whenever the synchronized sample agrees with enc again.
  always_comb begin
    upd = 2'b00;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s[i] == enc_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        cnt_d[i] = '0;
        upd[i]   = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    enc_d  = enc_q ^ upd;
    step_d = upd[0] ^ upd[1];
    // A simultaneous two-bit jump beats a same-cycle clear.
    err_d  = (upd[0] & upd[1]) | (err_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < SYNC_STAGES; j++) begin
        sync_q[j] <= 2'b00;
      end
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      enc_q    <= 2'b00;
      step_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      for (int j = 0; j < SYNC_STAGES; j++) begin
        sync_q[j] <= sync_d[j];
      end
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
      enc_q    <= enc_d;
      step_q   <= step_d;
      err_q    <= err_d;
    end
  end

  assign enc  = enc_q;
  assign step = step_q;
  assign err  = err_q;

endmodule

// File: tb/tb_quadrature_input_filter.sv
// Directed bench for quadrature_input_filter at default parameters (6-cycle pin-to-enc latency).
module tb_quadrature_input_filter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] enc_raw = 2'b00;
  logic       err_clr = 1'b0;
  logic [1:0] enc;
  logic       step;
  logic       err;

  int checks = 0;
  int passes = 0;

  quadrature_input_filter #(
    .SYNC_STAGES(2),
    .FILTER_CYCLES(4),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enc_raw(enc_raw),
    .err_clr(err_clr),
    .enc(enc),
    .step(step),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    enc_raw = 2'b00;
    err_clr = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [1:0] exp_enc;
    logic       exp_err;
    reset   = 1'b0;
    enc_raw = 2'b11;
    err_clr = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if ({enc, step, err} !== 4'b0000)
        $display("FAIL reset_hold cyc=%0d enc=%b step=%b err=%b want enc=00 step=0 err=0", c, enc, step, err);
      else passes++;
    end
    reset = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp_enc = (e >= 6) ? 2'b11 : 2'b00;
      exp_err = (e >= 6);
      checks++;
      if (enc !== exp_enc || step !== 1'b0 || err !== exp_err)
        $display("FAIL reset_release edge=%0d enc=%b step=%b err=%b want enc=%b step=0 err=%b",
                 e, enc, step, err, exp_enc, exp_err);
      else passes++;
    end
  endtask

  task automatic test_latency();
    logic [1:0] exp_enc;
    logic       exp_step;
    do_reset();
    enc_raw = 2'b01;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp_enc  = (e >= 6) ? 2'b01 : 2'b00;
      exp_step = (e == 6);
      checks++;
      if (enc !== exp_enc || step !== exp_step || err !== 1'b0)
        $display("FAIL latency_rise_a edge=%0d enc=%b step=%b err=%b want enc=%b step=%b err=0",
                 e, enc, step, err, exp_enc, exp_step);
      else passes++;
    end
    enc_raw = 2'b11;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp_enc  = (e >= 6) ? 2'b11 : 2'b01;
      exp_step = (e == 6);
      checks++;
      if (enc !== exp_enc || step !== exp_step || err !== 1'b0)
        $display("FAIL latency_rise_b edge=%0d enc=%b step=%b err=%b want enc=%b step=%b err=0",
                 e, enc, step, err, exp_enc, exp_step);
      else passes++;
    end
  endtask

  task automatic test_glitch_reject();
    int bad;
    logic [1:0] exp_enc;
    logic       exp_step;
    do_reset();
    bad = 0;
    for (int e = 1; e <= 14; e++) begin
      enc_raw = (e <= 3) ? 2'b01 : 2'b00;
      tick();
      if (enc !== 2'b00 || step !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL glitch_3cyc bad_edges=%0d want 0 (enc must stay 00, no step)", bad);
    else passes++;
    for (int e = 1; e <= 8; e++) begin
      enc_raw = (e <= 4) ? 2'b01 : 2'b00;
      tick();
      exp_enc  = (e >= 6) ? 2'b01 : 2'b00;
      exp_step = (e == 6);
      checks++;
      if (enc !== exp_enc || step !== exp_step)
        $display("FAIL glitch_4cyc edge=%0d enc=%b step=%b want enc=%b step=%b", e, enc, step, exp_enc, exp_step);
      else passes++;
    end
  endtask

  task automatic test_restart_on_bounce();
    logic [7:0] pat;
    logic [1:0] exp_enc;
    logic       exp_step;
    do_reset();
    pat = 8'b1111_0111;  // edge1 is bit0: 1,1,1,0,1,1,1,1
    for (int e = 1; e <= 11; e++) begin
      enc_raw = {(e <= 8) ? pat[e-1] : 1'b1, 1'b0};
      tick();
      exp_enc  = (e >= 10) ? 2'b10 : 2'b00;
      exp_step = (e == 10);
      checks++;
      if (enc !== exp_enc || step !== exp_step)
        $display("FAIL bounce_restart edge=%0d enc=%b step=%b want enc=%b step=%b", e, enc, step, exp_enc, exp_step);
      else passes++;
    end
  endtask

  task automatic test_illegal_jump();
    do_reset();
    enc_raw = 2'b11;
    repeat (5) tick();
    checks++;
    if (enc !== 2'b00 || err !== 1'b0)
      $display("FAIL illegal_pre edge=5 enc=%b err=%b want enc=00 err=0", enc, err);
    else passes++;
    tick();
    checks++;
    if (enc !== 2'b11 || err !== 1'b1 || step !== 1'b0)
      $display("FAIL illegal_set enc=%b err=%b step=%b want enc=11 err=1 step=0", enc, err, step);
    else passes++;
    tick();
    checks++;
    if (err !== 1'b1) $display("FAIL illegal_sticky err=%b want 1", err);
    else passes++;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (err !== 1'b0 || enc !== 2'b11) $display("FAIL err_clr err=%b enc=%b want err=0 enc=11", err, enc);
    else passes++;
    enc_raw = 2'b00;
    err_clr = 1'b1;
    repeat (5) tick();
    checks++;
    if (err !== 1'b0 || enc !== 2'b11) $display("FAIL illegal2_pre err=%b enc=%b want err=0 enc=11", err, enc);
    else passes++;
    tick();
    checks++;
    if (err !== 1'b1 || enc !== 2'b00 || step !== 1'b0)
      $display("FAIL set_beats_clr err=%b enc=%b step=%b want err=1 enc=00 step=0", err, enc, step);
    else passes++;
    err_clr = 1'b0;
  endtask

  task automatic test_reset_mid_filter();
    logic [1:0] exp_enc;
    do_reset();
    enc_raw = 2'b01;
    repeat (4) tick();
    reset = 1'b0;
    #1;
    checks++;
    if (enc !== 2'b00 || step !== 1'b0 || err !== 1'b0)
      $display("FAIL mid_reset_async enc=%b step=%b err=%b want 00/0/0", enc, step, err);
    else passes++;
    tick();
    reset = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      exp_enc = (e >= 6) ? 2'b01 : 2'b00;
      checks++;
      if (enc !== exp_enc || step !== (e == 6))
        $display("FAIL mid_reset_relatch edge=%0d enc=%b step=%b want enc=%b step=%0d", e, enc, step, exp_enc, (e == 6));
      else passes++;
    end
  endtask

  task automatic test_cw_sequence();
    logic [1:0] seq [4];
    logic [1:0] prev;
    int steps;
    int pos;
    seq[0] = 2'b01;
    seq[1] = 2'b11;
    seq[2] = 2'b10;
    seq[3] = 2'b00;
    do_reset();
    prev  = 2'b00;
    steps = 0;
    pos   = 0;
    for (int n = 0; n < 5; n++) begin
      for (int c = 0; c < 10; c++) begin
        enc_raw = (n < 4) ? seq[n] : 2'b00;
        tick();
        if (step === 1'b1) steps++;
        if (enc !== prev) begin
          case ({prev, enc})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: pos++;
            4'b0100, 4'b1101, 4'b1011, 4'b0010: pos--;
            default: ;
          endcase
          prev = enc;
        end
      end
    end
    checks++;
    if (steps != 4) $display("FAIL cw_step_count got=%0d want=4", steps);
    else passes++;
    checks++;
    if (pos != 4) $display("FAIL cw_position got=%0d want=4", pos);
    else passes++;
    checks++;
    if (err !== 1'b0 || enc !== 2'b00) $display("FAIL cw_final err=%b enc=%b want err=0 enc=00", err, enc);
    else passes++;
  endtask

  initial begin
    #2;
    test_reset();
    test_latency();
    test_glitch_reject();
    test_restart_on_bounce();
    test_illegal_jump();
    test_reset_mid_filter();
    test_cw_sequence();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
